multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS sequencer: a Moore FSM steps the shared datapath (one ALU, one unified memory, IR/ALUOut regs)
//  through FETCH/DECODE/EXEC/MEM/WB per instruction. Holds memory accesses until mem_ready, flags illegal ops/timeouts.
//  Supported set: addu add subu sub and or nor slt, ori, lw, sw, beq, j, jal.
// PARAMETERS
//  MAX_WAIT   200  max cycles mem_req may stay unacknowledged before timeout
//  WAIT_W     8    width of wait counter; must satisfy 2**WAIT_W > MAX_WAIT
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-low reset
//  OP         in   6  IR[31:26] (IR written only when IRWrite)
//  Funct      in   6  IR[5:0]
//  zero       in   1  ALU zero flag, combinational, same cycle
//  mem_ready  in   1  memory ack for current mem_req
//  PCWrite    out  1  load PC this cycle
//  PCSrc      out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],2'b00}
//  IorD       out  1  0 mem addr=PC, 1 mem addr=ALUOut
//  mem_req    out  1  memory access request
//  MemWrite   out  1  qualifies mem_req as write
//  IRWrite    out  1  load IR from memory read data
//  RegDst     out  2  00 rt, 01 rd, 10 $31
//  MemtoReg   out  2  00 ALUOut, 01 MDR, 10 PC (already PC+4)
//  RegWrite   out  1  register file write
//  ALUSrcA    out  1  0 PC, 1 rs
//  ALUSrcB    out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2
//  ALUOp      out  3  000 ADD 001 SUB 010 AND 011 OR 100 NOR 101 SLT
//  EXTOp      out  2  00 zero-extend, 01 sign-extend
//  retire     out  1  1-cycle pulse in final state of each instruction
//  err_code   out  2  00 none, 01 illegal instr, 10 memory timeout (sticky)
//  state      out  4  current state encoding (debug)
// BEHAVIOUR
//  - reset low: state=S_RST(0) immediately; every output 0. First clk after release -> S_FETCH. Reset mid-op aborts.
//  - Outputs decode state and OP/Funct only (Moore); all unlisted outputs 0 in each state.
//  - FETCH(1): mem_req,IorD=0,IRWrite,ALUSrcA=0,ALUSrcB=01,ALUOp=ADD; PCWrite,IRWrite only in cycle mem_ready=1
//    -> DECODE. IRWrite/PCWrite are gated by mem_ready.
//  - DECODE(2): ALUSrcA=0,ALUSrcB=11,ALUOp=ADD,EXTOp=01 (branch target into ALUOut). Next: R->EXE_R(3), ori->EXE_I(4),
//    lw/sw->MEM_ADDR(5), beq->BRANCH(9), j/jal->JUMP(10); unknown OP or R-type Funct -> ERR(11), err_code=01.
//  - EXE_R: ALUSrcA=1,ALUSrcB=00,ALUOp per Funct (add/addu ADD, sub/subu SUB) -> WB_ALU(8) with RegDst=01.
//  - EXE_I: ALUSrcA=1,ALUSrcB=10,EXTOp=00,ALUOp=OR -> WB_ALU with RegDst=00.
//  - WB_ALU(8): RegWrite,MemtoReg=00, RegDst per above, retire -> FETCH.
//  - MEM_ADDR: ALUSrcA=1,ALUSrcB=10,EXTOp=01,ALUOp=ADD -> MEM_RD(6) for lw, MEM_WR(7) for sw.
//  - MEM_RD: mem_req,IorD=1; on mem_ready -> WB_MEM(12): RegWrite,RegDst=00,MemtoReg=01,retire -> FETCH.
//  - MEM_WR: mem_req,MemWrite,IorD=1; on mem_ready retire -> FETCH.
//  - BRANCH: ALUSrcA=1,ALUSrcB=00,ALUOp=SUB,PCSrc=01,PCWrite=zero,retire -> FETCH.
//  - JUMP: PCWrite,PCSrc=10,retire; jal also RegWrite,RegDst=10,MemtoReg=10 -> FETCH.
//  - Wait counter: cleared on entry to any mem_req state and on mem_ready; increments each cycle mem_req=1 and
//    mem_ready=0; reaching MAX_WAIT -> ERR, err_code=10; mem_ready in that same cycle wins (no error).
//  - ERR: all outputs 0 except err_code/state; held until reset.
//  - Latency with zero waits: R/ori/sw 4, lw 5, beq/j/jal 3 cycles; each mem wait cycle adds 1.
// TESTING
//  1 reset low mid-MEM_WR -> mem_req,MemWrite drop same cycle, state=0; release -> FETCH next clk.
//  2 addu (OP=0,Funct=0x21), mem_ready tied 1 -> states 1,2,3,8; retire in 4th cycle, RegDst=01 ALUOp=000.
//  3 lw (OP=0x23), data mem_ready after 3 low cycles -> mem_req held 4 cycles in MEM_RD, retire at cycle 8.
//  4 beq (OP=0x04) zero=1 -> PCWrite=1 PCSrc=01 in cycle 3; repeat zero=0 -> PCWrite=0, retire still pulses.
//  5 jal (OP=0x03) -> cycle 3: PCWrite PCSrc=10 RegWrite RegDst=10 MemtoReg=10.
//  6 OP=0x3F -> err_code=01 after DECODE; mem_ready held 0 in FETCH -> err_code=10 after MAX_WAIT cycles.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if : control/status bundle between sequencer and datapath
// Revision 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       mem_req;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] EXTOp;
  logic       retire;
  logic [1:0] err_code;
  logic [3:0] state;

  modport master (
    input  OP, Funct, zero, mem_ready,
    output PCWrite, PCSrc, IorD, mem_req, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, EXTOp, retire, err_code, state
  );

  modport slave (
    output OP, Funct, zero, mem_ready,
    input  PCWrite, PCSrc, IorD, mem_req, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, EXTOp, retire, err_code, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : Moore sequencer for a multi-cycle MIPS datapath
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int MAX_WAIT = 200,
  parameter int WAIT_W   = 8
) (
  input  wire               clk,
  input  wire               reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXE_R    = 4'd3;
  localparam logic [3:0] S_EXE_I    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ERR      = 4'd11;
  localparam logic [3:0] S_WB_MEM   = 4'd12;

  localparam logic [5:0] c_OP_R   = 6'h00;
  localparam logic [5:0] c_OP_J   = 6'h02;
  localparam logic [5:0] c_OP_JAL = 6'h03;
  localparam logic [5:0] c_OP_BEQ = 6'h04;
  localparam logic [5:0] c_OP_ORI = 6'h0D;
  localparam logic [5:0] c_OP_LW  = 6'h23;
  localparam logic [5:0] c_OP_SW  = 6'h2B;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_NOR = 3'd4;
  localparam logic [2:0] c_ALU_SLT = 3'd5;

  localparam logic [1:0] c_ERR_ILL = 2'b01;
  localparam logic [1:0] c_ERR_TMO = 2'b10;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [1:0]        r_err;
  logic [1:0]        w_err_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_timeout;
  logic              w_funct_ok;
  logic [2:0]        w_funct_alu;

  logic       w_pcwrite, w_iord, w_mem_req, w_memwrite, w_irwrite;
  logic       w_regwrite, w_alusrca, w_retire;
  logic [1:0] w_pcsrc, w_regdst, w_memtoreg, w_alusrcb, w_extop;
  logic [2:0] w_aluop;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = c_ALU_ADD;
    case (bus.Funct)
      6'h20, 6'h21: w_funct_alu = c_ALU_ADD;
      6'h22, 6'h23: w_funct_alu = c_ALU_SUB;
      6'h24:        w_funct_alu = c_ALU_AND;
      6'h25:        w_funct_alu = c_ALU_OR;
      6'h27:        w_funct_alu = c_ALU_NOR;
      6'h2A:        w_funct_alu = c_ALU_SLT;
      default:      w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0; w_iord    = 1'b0; w_mem_req  = 1'b0; w_memwrite = 1'b0;
    w_irwrite  = 1'b0; w_regwrite = 1'b0; w_alusrca = 1'b0; w_retire   = 1'b0;
    w_pcsrc    = 2'b00; w_regdst  = 2'b00; w_memtoreg = 2'b00;
    w_alusrcb  = 2'b00; w_extop   = 2'b00; w_aluop    = c_ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = bus.mem_ready;
        w_pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_extop   = 2'b01;
      end
      S_EXE_R: begin
        w_alusrca = 1'b1;
        w_aluop   = w_funct_alu;
      end
      S_EXE_I: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = c_ALU_OR;
      end
      S_MEM_ADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_extop   = 2'b01;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_retire   = bus.mem_ready;
      end
      S_WB_ALU: begin
        w_regwrite = 1'b1;
        // IR is stable until the next fetch, so OP still selects rd vs rt here
        w_regdst   = (bus.OP == c_OP_R) ? 2'b01 : 2'b00;
        w_retire   = 1'b1;
      end
      S_WB_MEM: begin
        w_regwrite = 1'b1;
        w_memtoreg = 2'b01;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = c_ALU_SUB;
        w_pcsrc   = 2'b01;
        w_pcwrite = bus.zero;
        w_retire  = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b10;
        w_retire  = 1'b1;
        if (bus.OP == c_OP_JAL) begin
          w_regwrite = 1'b1;
          w_regdst   = 2'b10;
          w_memtoreg = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // mem_ready on the last allowed cycle takes priority over the timeout
  assign w_timeout = w_mem_req && !bus.mem_ready && (r_wait == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.OP)
          c_OP_R:           w_next = w_funct_ok ? S_EXE_R : S_ERR;
          c_OP_ORI:         w_next = S_EXE_I;
          c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_J, c_OP_JAL: w_next = S_JUMP;
          default:          w_next = S_ERR;
        endcase
        if (w_next == S_ERR) w_err_next = c_ERR_ILL;
      end
      S_EXE_R, S_EXE_I: w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = (bus.OP == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) w_next = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_ERR:      w_next = S_ERR;
      default:    w_next = S_RST;
    endcase
    if (w_timeout) begin
      w_next     = S_ERR;
      w_err_next = c_ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
      r_err   <= 2'b00;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_mem_req && !bus.mem_ready) r_wait <= r_wait + WAIT_W'(1);
      else                             r_wait <= '0;
    end
  end

  assign bus.PCWrite  = w_pcwrite;
  assign bus.PCSrc    = w_pcsrc;
  assign bus.IorD     = w_iord;
  assign bus.mem_req  = w_mem_req;
  assign bus.MemWrite = w_memwrite;
  assign bus.IRWrite  = w_irwrite;
  assign bus.RegDst   = w_regdst;
  assign bus.MemtoReg = w_memtoreg;
  assign bus.RegWrite = w_regwrite;
  assign bus.ALUSrcA  = w_alusrca;
  assign bus.ALUSrcB  = w_alusrcb;
  assign bus.ALUOp    = w_aluop;
  assign bus.EXTOp    = w_extop;
  assign bus.retire   = w_retire;
  assign bus.err_code = r_err;
  assign bus.state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed self-checking bench for multicycle_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MAX_WAIT(200), .WAIT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [22:0] w_outs;
  assign w_outs = {bus.PCWrite, bus.PCSrc, bus.IorD, bus.mem_req, bus.MemWrite,
                   bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.EXTOp, bus.retire, bus.err_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from FETCH: issue opcode with instant fetch, stop one state past DECODE
  task automatic issue(input logic [5:0] op, input logic [5:0] funct);
    bus.OP        = op;
    bus.Funct     = funct;
    bus.mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_r(input logic [5:0] funct, input int exp_alu);
    issue(6'h00, funct);
    chk($sformatf("r_state_%0h", funct), int'(bus.state), 3);
    chk($sformatf("r_aluop_%0h", funct), int'(bus.ALUOp), exp_alu);
    tick();
    chk($sformatf("r_wb_%0h", funct), int'(bus.state), 8);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.OP        = 6'h00;
    bus.Funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    #12;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_outs", int'(w_outs), 0);
    reset = 1'b1;
    tick();
    chk("fetch_state", int'(bus.state), 1);
    chk("fetch_req", int'(bus.mem_req), 1);
    chk("fetch_irw_wait", int'(bus.IRWrite), 0);
    chk("fetch_pcw_wait", int'(bus.PCWrite), 0);

    // addu with memory always ready
    bus.OP = 6'h00; bus.Funct = 6'h21; bus.mem_ready = 1'b1;
    #1;
    chk("fetch_irw", int'(bus.IRWrite), 1);
    chk("fetch_pcw", int'(bus.PCWrite), 1);
    chk("fetch_srcb", int'(bus.ALUSrcB), 1);
    tick();
    chk("dec_state", int'(bus.state), 2);
    chk("dec_srcb", int'(bus.ALUSrcB), 3);
    chk("dec_ext", int'(bus.EXTOp), 1);
    tick();
    chk("addu_state", int'(bus.state), 3);
    chk("addu_srca", int'(bus.ALUSrcA), 1);
    chk("addu_aluop", int'(bus.ALUOp), 0);
    chk("addu_noret", int'(bus.retire), 0);
    tick();
    chk("addu_wb", int'(bus.state), 8);
    chk("addu_retire", int'(bus.retire), 1);
    chk("addu_regdst", int'(bus.RegDst), 1);
    chk("addu_regwr", int'(bus.RegWrite), 1);
    tick();
    chk("addu_back", int'(bus.state), 1);

    run_r(6'h22, 1);
    run_r(6'h24, 2);
    run_r(6'h25, 3);
    run_r(6'h27, 4);
    run_r(6'h2A, 5);

    // ori
    issue(6'h0D, 6'h00);
    chk("ori_state", int'(bus.state), 4);
    chk("ori_aluop", int'(bus.ALUOp), 3);
    chk("ori_srcb", int'(bus.ALUSrcB), 2);
    chk("ori_ext", int'(bus.EXTOp), 0);
    tick();
    chk("ori_regdst", int'(bus.RegDst), 0);
    chk("ori_retire", int'(bus.retire), 1);
    tick();

    // lw with three not-ready cycles in MEM_RD
    issue(6'h23, 6'h00);
    chk("lw_addr", int'(bus.state), 5);
    chk("lw_addr_ext", int'(bus.EXTOp), 1);
    bus.mem_ready = 1'b0;
    tick();
    chk("lw_rd", int'(bus.state), 6);
    chk("lw_iord", int'(bus.IorD), 1);
    chk("lw_req", int'(bus.mem_req), 1);
    tick();
    tick();
    tick();
    chk("lw_rd_hold", int'(bus.state), 6);
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_rd_noret", int'(bus.retire), 0);
    tick();
    chk("lw_wbmem", int'(bus.state), 12);
    chk("lw_retire", int'(bus.retire), 1);
    chk("lw_memtoreg", int'(bus.MemtoReg), 1);
    chk("lw_regdst", int'(bus.RegDst), 0);
    tick();
    chk("lw_back", int'(bus.state), 1);

    // sw completing
    issue(6'h2B, 6'h00);
    tick();
    chk("sw_wr", int'(bus.state), 7);
    chk("sw_memwr", int'(bus.MemWrite), 1);
    chk("sw_retire", int'(bus.retire), 1);
    tick();
    chk("sw_back", int'(bus.state), 1);

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      issue(6'h04, 6'h00);
      bus.zero = z[0];
      #1;
      chk("beq_state", int'(bus.state), 9);
      chk("beq_pcw", int'(bus.PCWrite), z);
      chk("beq_pcsrc", int'(bus.PCSrc), 1);
      chk("beq_aluop", int'(bus.ALUOp), 1);
      chk("beq_retire", int'(bus.retire), 1);
      tick();
    end
    bus.zero = 1'b0;

    // jal
    issue(6'h03, 6'h00);
    chk("jal_state", int'(bus.state), 10);
    chk("jal_pcw", int'(bus.PCWrite), 1);
    chk("jal_pcsrc", int'(bus.PCSrc), 2);
    chk("jal_regwr", int'(bus.RegWrite), 1);
    chk("jal_regdst", int'(bus.RegDst), 2);
    chk("jal_memtoreg", int'(bus.MemtoReg), 2);
    tick();

    // mem_ready on the last allowed wait cycle beats the timeout
    bus.mem_ready = 1'b0;
    repeat (199) tick();
    chk("edge_hold", int'(bus.state), 1);
    bus.OP = 6'h02; bus.mem_ready = 1'b1;
    tick();
    chk("edge_dec", int'(bus.state), 2);
    chk("edge_noerr", int'(bus.err_code), 0);
    tick();
    chk("j_pcsrc", int'(bus.PCSrc), 2);
    chk("j_noregwr", int'(bus.RegWrite), 0);
    tick();

    // reset asserted in the middle of a stalled store
    issue(6'h2B, 6'h00);
    bus.mem_ready = 1'b0;
    tick();
    chk("swr_req", int'(bus.mem_req), 1);
    reset = 1'b0;
    #1;
    chk("swr_state", int'(bus.state), 0);
    chk("swr_req_drop", int'(bus.mem_req), 0);
    chk("swr_wr_drop", int'(bus.MemWrite), 0);
    reset = 1'b1;
    tick();
    chk("swr_fetch", int'(bus.state), 1);

    // illegal opcode and illegal funct
    issue(6'h3F, 6'h00);
    chk("ill_state", int'(bus.state), 11);
    chk("ill_err", int'(bus.err_code), 1);
    chk("ill_outs", int'(w_outs[22:2]), 0);
    reset = 1'b0; #1; reset = 1'b1;
    tick();
    issue(6'h00, 6'h08);
    chk("illf_err", int'(bus.err_code), 1);

    // fetch timeout
    reset = 1'b0; #1; reset = 1'b1;
    chk("tmo_clr", int'(bus.err_code), 0);
    bus.mem_ready = 1'b0;
    tick();
    repeat (199) tick();
    chk("tmo_pre", int'(bus.state), 1);
    tick();
    chk("tmo_state", int'(bus.state), 11);
    chk("tmo_err", int'(bus.err_code), 2);
    bus.mem_ready = 1'b1;
    tick();
    chk("tmo_sticky", int'(bus.err_code), 2);
    chk("tmo_stay", int'(bus.state), 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
